// File: rtl/control_unit_if.sv
// Control-side bundle between control_unit and the RV64I datapath/memories.
// master = control unit, slave = datapath and memory side.
interface control_unit_if #(
    parameter int BYTE_NUM = 8
);
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                zero;
    logic                negative;
    logic                carry_out;
    logic                overflow;
    logic                instruction_mem_ack;
    logic                data_mem_ack;

    logic                instruction_mem_enable;
    logic                data_mem_read_enable;
    logic                data_mem_write_enable;
    logic [BYTE_NUM-1:0] data_mem_byte_enable;
    logic                alua_src;
    logic                alub_src;
    logic                aluy_src;
    logic [2:0]          alu_src;
    logic                carry_in;
    logic                arithmetic;
    logic                alupc_src;
    logic                pc_src;
    logic                pc_enable;
    logic [2:0]          read_data_src;
    logic [1:0]          write_register_src;
    logic                write_register_enable;
    logic                halted;

    modport master (
        input  opcode, funct3, funct7, zero, negative, carry_out, overflow,
               instruction_mem_ack, data_mem_ack,
        output instruction_mem_enable, data_mem_read_enable, data_mem_write_enable,
               data_mem_byte_enable, alua_src, alub_src, aluy_src, alu_src, carry_in,
               arithmetic, alupc_src, pc_src, pc_enable, read_data_src,
               write_register_src, write_register_enable, halted
    );

    modport slave (
        output opcode, funct3, funct7, zero, negative, carry_out, overflow,
               instruction_mem_ack, data_mem_ack,
        input  instruction_mem_enable, data_mem_read_enable, data_mem_write_enable,
               data_mem_byte_enable, alua_src, alub_src, aluy_src, alu_src, carry_in,
               arithmetic, alupc_src, pc_src, pc_enable, read_data_src,
               write_register_src, write_register_enable, halted
    );
endinterface

// File: rtl/control_unit.sv
// Multicycle RV64I control FSM: fetch/decode/execute sequencing, memory handshakes, branch resolution.
// Define CONTROL_UNIT_HALT_EN to stop on SYSTEM/undecoded opcodes; otherwise they retire as NOPs.
module control_unit #(
    parameter int BYTE_NUM = 8
) (
    input logic            clock,
    input logic            reset,
    control_unit_if.master bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

`ifdef CONTROL_UNIT_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_ALU_WB, S_LOAD, S_STORE, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    state_e state_q, state_d;
    logic   imem_req_q, imem_req_d;
    logic   rd_req_q, rd_req_d;
    logic   wr_req_q, wr_req_d;
    logic   imem_ack, dmem_ack;
    logic   is_reg_op, is_imm_op, is_w_op, known_op, taken;
    int     store_lanes;
    logic   unused_funct7;

    // Acks count only while the matching request is actually on the bus.
    assign imem_ack    = imem_req_q & bus.instruction_mem_ack;
    assign dmem_ack    = (rd_req_q | wr_req_q) & bus.data_mem_ack;

    assign is_reg_op   = (bus.opcode == OPC_OP) || (bus.opcode == OPC_OP_32);
    assign is_imm_op   = (bus.opcode == OPC_IMM) || (bus.opcode == OPC_IMM_32);
    assign is_w_op     = (bus.opcode == OPC_OP_32) || (bus.opcode == OPC_IMM_32);
    assign known_op    = bus.opcode inside {OPC_LOAD, OPC_IMM, OPC_AUIPC, OPC_IMM_32, OPC_STORE,
                                            OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR,
                                            OPC_JAL};
    assign store_lanes = 1 << bus.funct3[1:0];
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (!known_op) begin
                    state_d = HaltEn ? S_HALT : S_FETCH;
                end else begin
                    case (bus.opcode)
                        OPC_LOAD:          state_d = S_LOAD;
                        OPC_STORE:         state_d = S_STORE;
                        OPC_BRANCH:        state_d = S_BRANCH;
                        OPC_JAL, OPC_JALR: state_d = S_JUMP;
                        default:           state_d = S_ALU_WB;
                    endcase
                end
            end
            S_LOAD, S_STORE: if (dmem_ack) state_d = S_FETCH;
            S_HALT:   state_d = HaltEn ? S_HALT : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Requests are registered from the next state so reset leaves every enable low.
    assign imem_req_d = (state_d == S_FETCH);
    assign rd_req_d   = (state_d == S_LOAD);
    assign wr_req_d   = (state_d == S_STORE);

    assign bus.instruction_mem_enable = imem_req_q;
    assign bus.data_mem_read_enable   = rd_req_q;
    assign bus.data_mem_write_enable  = wr_req_q;
    assign bus.halted                 = HaltEn && (state_q == S_HALT);

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.negative ^ bus.overflow;
            3'b101:  taken = ~(bus.negative ^ bus.overflow);
            3'b110:  taken = ~bus.carry_out;
            3'b111:  taken = bus.carry_out;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        bus.data_mem_byte_enable  = '0;
        bus.alua_src              = 1'b0;
        bus.alub_src              = 1'b0;
        bus.aluy_src              = 1'b0;
        bus.alu_src               = 3'b000;
        bus.carry_in              = 1'b0;
        bus.arithmetic            = 1'b0;
        bus.alupc_src             = 1'b0;
        bus.pc_src                = 1'b0;
        bus.pc_enable             = 1'b0;
        bus.read_data_src         = 3'b000;
        bus.write_register_src    = 2'b00;
        bus.write_register_enable = 1'b0;

        case (state_q)
            S_DECODE: bus.pc_enable = !HaltEn && !known_op;
            S_ALU_WB: begin
                // LUI/AUIPC carry junk in funct3; force a plain add.
                if (is_reg_op || is_imm_op) bus.alu_src = bus.funct3;
                bus.alua_src   = (bus.opcode == OPC_AUIPC);
                bus.alub_src   = is_reg_op;
                bus.aluy_src   = is_w_op;
                bus.arithmetic = (is_reg_op || (is_imm_op && bus.funct3 == 3'b101)) && bus.funct7[5];
                bus.carry_in   = (is_reg_op && bus.funct3 == 3'b000 && bus.funct7[5]) ||
                                 ((is_reg_op || is_imm_op) && bus.funct3[2:1] == 2'b01);
                bus.write_register_src    = 2'b10;
                bus.write_register_enable = 1'b1;
                bus.pc_enable             = 1'b1;
            end
            S_LOAD: begin
                bus.read_data_src         = {~bus.funct3[2], bus.funct3[1:0]};
                bus.write_register_enable = dmem_ack;
                bus.pc_enable             = dmem_ack;
            end
            S_STORE: begin
                for (int i = 0; i < BYTE_NUM; i++) bus.data_mem_byte_enable[i] = (i < store_lanes);
                bus.pc_enable = dmem_ack;
            end
            S_BRANCH: begin
                bus.alub_src   = 1'b1;
                bus.arithmetic = 1'b1;
                bus.carry_in   = 1'b1;
                bus.pc_src     = taken;
                bus.pc_enable  = 1'b1;
            end
            S_JUMP: begin
                bus.alupc_src             = (bus.opcode == OPC_JALR);
                bus.write_register_src    = 2'b01;
                bus.write_register_enable = 1'b1;
                bus.pc_src                = 1'b1;
                bus.pc_enable             = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
